uc_multiplicador: RTL and testbench
===================================

Name: uc_multiplicador

Overview:
- Control unit for the 16-bit shift-and-add multiplier datapath.
- Sequences the 5:1 accumulator-input mux (select `op[2:0]`) and the accumulator/multiplier register enables, with a start/done handshake to the host.
- Holds an internal iteration counter. The only datapath status it consumes is the multiplier-register LSB.
- Sits between the top-level multiplier wrapper and its datapath.

Parameters:
- N, 8, number of multiplier bits to process (iterations); N >= 1, N <= 16.
- CW, $clog2(N) (minimum 1), iteration counter width; derived, not overridden.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- iniciar  input  1  start request; sampled only in OCIOSO.
- cancelar  input  1  synchronous abort; wins over every other transition.
- lsb_mult  input  1  current LSB of the datapath multiplier register.
- sel_mux  output  3  accumulator mux select: 000 zero, 001 acc+multiplicand, 010 acc>>1 (with carry-in), 011 unused, 100 hold.
- en_acc  output  1  accumulator register load enable.
- en_mult  output  1  multiplier register shift-right enable.
- carrega  output  1  load multiplicand/multiplier operand registers.
- ocupado  output  1  high in every state except OCIOSO.
- pronto  output  1  one-cycle done pulse.
- estado  output  3  state code for debug (OCIOSO=0, CARREGA=1, TESTA=2, SOMA=3, DESLOCA=4, FIM=5).

Behaviour:
- Moore FSM; all outputs decode from registered state only.
- Reset (reset_n=0, asynchronous):
  - state=OCIOSO, contador=0.
  - Outputs: sel_mux=100, en_acc=0, en_mult=0, carrega=0, ocupado=0, pronto=0, estado=0.
  - Reset mid-operation aborts immediately; no pronto is issued.
- OCIOSO: sel=100, all enables 0. iniciar=1 -> CARREGA.
- CARREGA: sel=000, en_acc=1, carrega=1. contador<=0. -> TESTA.
- TESTA: sel=100, enables 0. lsb_mult=1 -> SOMA; else -> DESLOCA.
- SOMA: sel=001, en_acc=1. -> DESLOCA.
- DESLOCA: sel=010, en_acc=1, en_mult=1.
  - contador==N-1 -> FIM.
  - Otherwise contador<=contador+1 -> TESTA.
- FIM: sel=100, pronto=1 for exactly one cycle. -> OCIOSO.
- cancelar=1 in any state -> OCIOSO at next edge, pronto not asserted.
  - If iniciar=1 in the same cycle while in OCIOSO, cancelar wins (stay OCIOSO).
- iniciar while ocupado=1 is ignored; it is not queued.
- iniciar held high through FIM restarts: FIM -> OCIOSO -> CARREGA (one idle cycle minimum).
- sel_mux=011 is never emitted; it is an assertion target.
- Latency: iniciar sampled at edge E0 gives pronto high after edge E(1+2N+P), where P = number of 1 bits tested.
  - N=8, P=0: E17.
  - N=8, P=8: E25.
- en_mult asserts exactly N times per completed operation.
- en_acc asserts 1+N+P times per completed operation.
- Counter wrap: contador never exceeds N-1. With N=1, DESLOCA goes directly to FIM.
- Illegal state encodings (6, 7) -> OCIOSO at next edge, outputs as OCIOSO.

Test Plan:
- Reset: assert reset_n=0 mid-SOMA -> outputs immediately at reset values, estado=0; after release, no pronto until a new iniciar.
- Zero multiplier: N=8, lsb_mult stream all 0, iniciar at E0 -> 8 DESLOCA, 0 SOMA, pronto high after E17 only, ocupado high E0..E17.
- Golden product: datapath model, 0x0D x 0x0B -> SOMA count 3, pronto after E20, accumulator = 0x008F.
- All ones: 0xFF x 0xFF -> pronto after E25, en_acc count 17, en_mult count 8, product 0xFE01.
- Abort and collision: cancelar=1 in third DESLOCA -> OCIOSO next edge, no pronto; iniciar with cancelar in OCIOSO -> stays OCIOSO; iniciar pulsed while ocupado -> no effect on cycle count.
- Back-to-back: iniciar held high -> pronto pulses separated by exactly 1 OCIOSO cycle plus the next latency; sel_mux never 011 (assertion over all tests).

Source files
------------

// File: rtl/uc_multiplicador.sv
// Control unit for the shift-and-add multiplier: sequences the accumulator mux,
// the register enables and the start/done handshake over N multiplier bits.
module uc_multiplicador #(
  parameter int N = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       cancelar,
  input  logic       lsb_mult,
  output logic [2:0] sel_mux,
  output logic       en_acc,
  output logic       en_mult,
  output logic       carrega,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] estado
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  localparam logic [2:0] SEL_ZERO  = 3'b000;
  localparam logic [2:0] SEL_SOMA  = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_HOLD  = 3'b100;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    TESTA   = 3'd2,
    SOMA    = 3'd3,
    DESLOCA = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t        state_q, state_d;
  logic [CW-1:0]  contador_q, contador_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OCIOSO;
      contador_q <= '0;
    end else begin
      state_q    <= state_d;
      contador_q <= contador_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    contador_d = contador_q;
    unique case (state_q)
      OCIOSO:  if (iniciar) state_d = CARREGA;
      CARREGA: begin
        contador_d = '0;
        state_d    = TESTA;
      end
      TESTA:   state_d = lsb_mult ? SOMA : DESLOCA;
      SOMA:    state_d = DESLOCA;
      DESLOCA: begin
        if (contador_q == ULTIMO) begin
          state_d = FIM;
        end else begin
          contador_d = contador_q + CW'(1);
          state_d    = TESTA;
        end
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
    // Abort overrides any transition, including a start request in OCIOSO.
    if (cancelar) state_d = OCIOSO;
  end

  // Moore decode: outputs depend on the registered state only; illegal
  // encodings decode exactly like OCIOSO.
  always_comb begin
    sel_mux = SEL_HOLD;
    en_acc  = 1'b0;
    en_mult = 1'b0;
    carrega = 1'b0;
    ocupado = 1'b1;
    pronto  = 1'b0;
    estado  = state_q;
    unique case (state_q)
      OCIOSO:  ocupado = 1'b0;
      CARREGA: begin
        sel_mux = SEL_ZERO;
        en_acc  = 1'b1;
        carrega = 1'b1;
      end
      TESTA:   ;
      SOMA: begin
        sel_mux = SEL_SOMA;
        en_acc  = 1'b1;
      end
      DESLOCA: begin
        sel_mux = SEL_SHIFT;
        en_acc  = 1'b1;
        en_mult = 1'b1;
      end
      FIM:     pronto = 1'b1;
      default: begin
        ocupado = 1'b0;
        estado  = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_uc_multiplicador.sv
// Self-checking bench for uc_multiplicador: a behavioural datapath closes the
// lsb_mult loop and results are compared against plain-arithmetic expectations.
module tb_uc_multiplicador;

  localparam int N = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic       cancelar = 1'b0;
  logic       lsb_mult;
  logic [2:0] sel_mux, estado;
  logic       en_acc, en_mult, carrega, ocupado, pronto;

  logic       iniciar1 = 1'b0;
  logic       lsb1 = 1'b0;
  logic [2:0] sel_mux1, estado1;
  logic       en_acc1, en_mult1, carrega1, ocupado1, pronto1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  uc_multiplicador #(.N(N)) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .cancelar(cancelar),
    .lsb_mult(lsb_mult), .sel_mux(sel_mux), .en_acc(en_acc), .en_mult(en_mult),
    .carrega(carrega), .ocupado(ocupado), .pronto(pronto), .estado(estado)
  );

  uc_multiplicador #(.N(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar1), .cancelar(cancelar),
    .lsb_mult(lsb1), .sel_mux(sel_mux1), .en_acc(en_acc1), .en_mult(en_mult1),
    .carrega(carrega1), .ocupado(ocupado1), .pronto(pronto1), .estado(estado1)
  );

  // Behavioural datapath: {acc, mult} shift together; acc keeps a carry bit.
  logic [7:0] a_op = '0, b_op = '0;
  logic [8:0] acc;
  logic [7:0] mult, mcand;
  assign lsb_mult = mult[0];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0; mult <= '0; mcand <= '0;
    end else begin
      if (carrega) begin
        mcand <= a_op;
        mult  <= b_op;
      end
      if (en_acc) begin
        case (sel_mux)
          3'b000:  acc <= '0;
          3'b001:  acc <= {1'b0, acc[7:0]} + {1'b0, mcand};
          3'b010:  acc <= acc >> 1;
          default: ;
        endcase
      end
      if (en_mult) mult <= {acc[0], mult[7:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      check("sel_never_011", 32'(sel_mux == 3'b011), 32'd0);
      check("sel1_never_011", 32'(sel_mux1 == 3'b011), 32'd0);
    end
  end

  // Runs one operation from OCIOSO; edge 0 is the edge that samples iniciar.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int pulse_at,
                        output int lat, output int n_acc, output int n_mult,
                        output int n_soma, output bit busy_ok);
    a_op = a; b_op = b;
    lat = -1; n_acc = 0; n_mult = 0; n_soma = 0; busy_ok = 1'b1;
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    for (int e = 0; e < 200; e++) begin
      if (e > 0) begin @(posedge clock); #1; end
      if (!ocupado) busy_ok = 1'b0;
      if (pronto) begin lat = e; break; end
      if (en_acc) n_acc++;
      if (en_mult) n_mult++;
      if (estado == 3'd3) n_soma++;
      iniciar = (e == pulse_at);
    end
    iniciar = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input int pulse_at);
    int lat, n_acc, n_mult, n_soma, p;
    bit busy_ok;
    p = $countones(b);
    run_op(a, b, pulse_at, lat, n_acc, n_mult, n_soma, busy_ok);
    check({tag, ".latency"}, 32'(lat), 32'(1 + 2 * N + p));
    check({tag, ".en_acc"}, 32'(n_acc), 32'(1 + N + p));
    check({tag, ".en_mult"}, 32'(n_mult), 32'(N));
    check({tag, ".soma"}, 32'(n_soma), 32'(p));
    check({tag, ".product"}, {16'd0, acc[7:0], mult}, 32'(a) * 32'(b));
    check({tag, ".busy"}, 32'(busy_ok), 32'd1);
    @(posedge clock); #1;
    check({tag, ".pulse_len"}, 32'(pronto), 32'd0);
    check({tag, ".idle"}, {29'd0, estado}, 32'd0);
  endtask

  initial begin
    int cnt, p1, p2, np;
    logic [7:0] ra, rb;

    // Reset state
    #12;
    check("rst.sel", {29'd0, sel_mux}, 32'h4);
    check("rst.en_acc", 32'(en_acc), 0);
    check("rst.en_mult", 32'(en_mult), 0);
    check("rst.carrega", 32'(carrega), 0);
    check("rst.ocupado", 32'(ocupado), 0);
    check("rst.pronto", 32'(pronto), 0);
    check("rst.estado", {29'd0, estado}, 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("idle.no_start", {29'd0, estado}, 0);

    do_op("zero", 8'h5A, 8'h00, -1);
    do_op("golden", 8'h0D, 8'h0B, -1);
    do_op("ones", 8'hFF, 8'hFF, -1);
    do_op("busy_pulse", 8'h37, 8'hA5, 5);

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op($sformatf("rand%0d", i), ra, rb, (i % 2 == 0) ? int'($urandom_range(1, 15)) : -1);
    end

    // Abort in the third DESLOCA
    a_op = 8'h11; b_op = 8'hFF;
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock); #1; iniciar = 1'b0;
    cnt = 0;
    for (int e = 0; e < 60 && cnt < 3; e++) begin
      if (estado == 3'd4) cnt++;
      if (cnt < 3) begin @(posedge clock); #1; end
    end
    check("abort.reached", 32'(cnt), 3);
    cancelar = 1'b1;
    @(posedge clock); #1;
    cancelar = 1'b0;
    check("abort.estado", {29'd0, estado}, 0);
    check("abort.ocupado", 32'(ocupado), 0);
    np = 0;
    for (int e = 0; e < 30; e++) begin @(posedge clock); #1; if (pronto) np++; end
    check("abort.no_pronto", 32'(np), 0);

    // iniciar and cancelar together in OCIOSO
    @(negedge clock); iniciar = 1'b1; cancelar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0; cancelar = 1'b0;
    check("collide.estado", {29'd0, estado}, 0);
    @(posedge clock); #1;
    check("collide.stay", {29'd0, estado}, 0);

    // Back-to-back with iniciar held high
    a_op = 8'h03; b_op = 8'h05;
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock); #1;
    p1 = -1; p2 = -1; np = 0;
    for (int e = 0; e < 100; e++) begin
      if (e > 0) begin @(posedge clock); #1; end
      if (pronto) begin
        np++;
        if (p1 < 0) p1 = e; else if (p2 < 0) p2 = e;
      end
      if (p2 >= 0) break;
    end
    iniciar = 1'b0;
    check("b2b.first", 32'(p1), 32'(1 + 2 * N + 2));
    check("b2b.second", 32'(p2), 32'(2 * (1 + 2 * N + 2) + 2));
    check("b2b.pulses", 32'(np), 2);
    for (int e = 0; e < 30; e++) begin @(posedge clock); #1; end
    check("b2b.idle", {29'd0, estado}, 0);

    // Asynchronous reset mid-SOMA
    a_op = 8'h21; b_op = 8'hFF;
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock); #1; iniciar = 1'b0;
    for (int e = 0; e < 20 && estado != 3'd3; e++) begin @(posedge clock); #1; end
    check("rst_mid.in_soma", {29'd0, estado}, 3);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid.sel", {29'd0, sel_mux}, 32'h4);
    check("rst_mid.en", {30'd0, en_acc, en_mult}, 0);
    check("rst_mid.carrega", 32'(carrega), 0);
    check("rst_mid.ocupado", 32'(ocupado), 0);
    check("rst_mid.pronto", 32'(pronto), 0);
    check("rst_mid.estado", {29'd0, estado}, 0);
    @(negedge clock); reset_n = 1'b1;
    np = 0;
    for (int e = 0; e < 40; e++) begin @(posedge clock); #1; if (pronto || ocupado) np++; end
    check("rst_mid.quiet", 32'(np), 0);

    // N=1 instance: DESLOCA goes straight to FIM
    for (int k = 0; k < 2; k++) begin
      lsb1 = k[0];
      @(negedge clock); iniciar1 = 1'b1;
      @(posedge clock); #1; iniciar1 = 1'b0;
      p1 = -1; cnt = 0;
      for (int e = 0; e < 20; e++) begin
        if (e > 0) begin @(posedge clock); #1; end
        if (pronto1) begin p1 = e; break; end
        if (en_mult1) cnt++;
      end
      check($sformatf("n1.latency%0d", k), 32'(p1), 32'(3 + k));
      check($sformatf("n1.en_mult%0d", k), 32'(cnt), 1);
      @(posedge clock); #1;
      check($sformatf("n1.idle%0d", k), {29'd0, estado1}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
